pc_sequencer: RTL and testbench

Program-counter stage that sits directly downstream of the main control decoder and upstream of instruction memory. It consumes the decoder's `branch_eq`, `branch_ne` and `jump` strobes together with the ALU `zero` flag and the current instruction word. It registers the next PC every cycle. It also tracks a two-state run/halt machine (halt on jump-to-self) and, optionally, counts taken control transfers.

---
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bundle between the control decoder / instruction memory side (master)
// and the PC sequencer (slave). CNT_W sizes the statistics counters.
interface pc_sequencer_if #(
   parameter int CNT_W = 16
) ();
   logic [31:0]      instr;
   logic             branch_eq;
   logic             branch_ne;
   logic             jump;
   logic             zero;
   logic             stall;
   logic [31:0]      pc;
   logic [31:0]      pc_plus4;
   logic             redirect;
   logic             halted;
   logic [CNT_W-1:0] taken_count;
   logic [CNT_W-1:0] jump_count;

   modport master (
      output instr, branch_eq, branch_ne, jump, zero, stall,
      input  pc, pc_plus4, redirect, halted, taken_count, jump_count
   );

   modport slave (
      input  instr, branch_eq, branch_ne, jump, zero, stall,
      output pc, pc_plus4, redirect, halted, taken_count, jump_count
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage: selects jump / branch / sequential next PC,
// registers it every unstalled cycle, and halts on a jump-to-self.
// Optional taken-branch / jump statistics are built when PC_STATS_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | normal fetch; PC advances unless stalled
// ST_HALT | jump-to-self seen; PC frozen until reset
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.slave  bus
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        redirect_q, redirect_d;

   logic [31:0] pc_plus4;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic        br_taken;
   logic [31:0] next_pc;
   logic        advance;

   // Next-PC candidates and priority select: jump over branch over sequential.
   always_comb begin
      pc_plus4  = pc_q + 32'd4;
      br_target = pc_plus4 + {{14{bus.instr[15]}}, bus.instr[15:0], 2'b00};
      j_target  = {pc_plus4[31:26], bus.instr[23:0], 2'b00};
      br_taken  = (bus.branch_eq & bus.zero) | (bus.branch_ne & ~bus.zero);
      if (bus.jump)
         next_pc = j_target;
      else if (br_taken)
         next_pc = br_target;
      else
         next_pc = pc_plus4;
   end

   // Run/halt next-state, PC and redirect update.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      redirect_d = 1'b0;
      advance    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (!bus.stall) begin
               advance = 1'b1;
               if (bus.jump && (j_target == pc_q)) begin
                  // Jump-to-self does not move the PC, so nothing is redirected.
                  state_d = ST_HALT;
               end else begin
                  pc_d       = next_pc;
                  redirect_d = bus.jump | br_taken;
               end
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State, PC and redirect registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         redirect_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.pc_plus4 = pc_plus4;
   assign bus.redirect = redirect_q;
   assign bus.halted   = (state_q == ST_HALT);

`ifdef PC_STATS_EN
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
   logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d;

   // Saturating statistics counters, stepped only on unstalled RUN edges.
   always_comb begin
      taken_cnt_d = taken_cnt_q;
      jump_cnt_d  = jump_cnt_q;
      if (advance) begin
         if (br_taken && !bus.jump && (taken_cnt_q != {CNT_W{1'b1}}))
            taken_cnt_d = taken_cnt_q + 1'b1;
         if (bus.jump && (jump_cnt_q != {CNT_W{1'b1}}))
            jump_cnt_d = jump_cnt_q + 1'b1;
      end
   end

   // Statistics counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         taken_cnt_q <= '0;
         jump_cnt_q  <= '0;
      end else begin
         taken_cnt_q <= taken_cnt_d;
         jump_cnt_q  <= jump_cnt_d;
      end
   end

   assign bus.taken_count = taken_cnt_q;
   assign bus.jump_count  = jump_cnt_q;
`else
   logic advance_unused;
   assign advance_unused  = advance;
   assign bus.taken_count = {CNT_W{1'b0}};
   assign bus.jump_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with RESET_PC = 0x40 and 2-bit counters
// so that saturation is reachable in a handful of transfers.
module tb_pc_sequencer;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   pc_sequencer_if #(.CNT_W(2)) bus ();

   pc_sequencer #(
      .RESET_PC (32'h0000_0040),
      .CNT_W    (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Expected counter value: the count when statistics are built, else 0.
   function automatic logic [31:0] cexp(input int n);
`ifdef PC_STATS_EN
      return n;
`else
      return (n == n) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic clear_in();
      bus.instr     = 32'h0;
      bus.branch_eq = 1'b0;
      bus.branch_ne = 1'b0;
      bus.jump      = 1'b0;
      bus.zero      = 1'b0;
      bus.stall     = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_jump(input logic [23:0] idx);
      clear_in();
      bus.jump  = 1'b1;
      bus.instr = {8'h02, idx};
      tick();
   endtask

   task automatic do_branch(input logic eq, input logic ne, input logic z, input logic [15:0] imm);
      clear_in();
      bus.branch_eq = eq;
      bus.branch_ne = ne;
      bus.zero      = z;
      bus.instr     = {16'h0400, imm};
      tick();
   endtask

   task automatic check_state(input string tag, input logic [31:0] pc_e, input logic red_e,
                              input logic [31:0] tk_e, input logic [31:0] jp_e);
      check({tag, "_pc"}, bus.pc, pc_e);
      check({tag, "_redirect"}, {31'b0, bus.redirect}, {31'b0, red_e});
      check({tag, "_taken"}, {30'b0, bus.taken_count}, tk_e);
      check({tag, "_jumps"}, {30'b0, bus.jump_count}, jp_e);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clear_in();
      reset = 1'b1;
      #1;
      check_state("reset", 32'h40, 1'b0, 0, 0);
      check("reset_halted", {31'b0, bus.halted}, 32'd0);
      check("reset_pc_plus4", bus.pc_plus4, 32'h44);
      #2 reset = 1'b0;

      // Sequential flow after reset.
      tick(); check_state("seq1", 32'h44, 1'b0, 0, 0);
      tick(); check_state("seq2", 32'h48, 1'b0, 0, 0);
      tick(); check_state("seq3", 32'h4C, 1'b0, 0, 0);

      // Stall over a jump to 0x40: hold twice, then take it once.
      clear_in();
      bus.jump  = 1'b1;
      bus.instr = {8'h02, 24'h000010};
      bus.stall = 1'b1;
      tick(); check_state("stall1", 32'h4C, 1'b0, cexp(0), cexp(0));
      tick(); check_state("stall2", 32'h4C, 1'b0, cexp(0), cexp(0));
      bus.stall = 1'b0;
      tick(); check_state("stall_rel", 32'h40, 1'b1, cexp(0), cexp(1));

      // Go to 0x100, then beq taken forward by 3 words.
      do_jump(24'h000040);                check_state("jmp100a", 32'h100, 1'b1, cexp(0), cexp(2));
      do_branch(1'b1, 1'b0, 1'b1, 16'h0003); check_state("beq_taken", 32'h110, 1'b1, cexp(1), cexp(2));
      clear_in(); tick();                 check_state("after_beq", 32'h114, 1'b0, cexp(1), cexp(2));

      // beq not taken.
      do_jump(24'h000040);                check_state("jmp100b", 32'h100, 1'b1, cexp(1), cexp(3));
      do_branch(1'b1, 1'b0, 1'b0, 16'h0003); check_state("beq_not", 32'h104, 1'b0, cexp(1), cexp(3));

      // Jump beats a simultaneous taken branch; jump counter is saturated.
      clear_in();
      bus.jump      = 1'b1;
      bus.branch_eq = 1'b1;
      bus.zero      = 1'b1;
      bus.instr     = {8'h02, 24'h000040};
      tick();                             check_state("jmp_prio", 32'h100, 1'b1, cexp(1), cexp(3));

      // bne taken backward, both strobes set, bne not taken.
      do_branch(1'b0, 1'b1, 1'b0, 16'hFFFE); check_state("bne_back", 32'hFC, 1'b1, cexp(2), cexp(3));
      do_branch(1'b1, 1'b1, 1'b1, 16'h0001); check_state("both_str", 32'h104, 1'b1, cexp(3), cexp(3));
      do_branch(1'b0, 1'b1, 1'b1, 16'h0001); check_state("bne_not", 32'h108, 1'b0, cexp(3), cexp(3));

      // Fourth and fifth taken branches: counter stays saturated.
      do_branch(1'b1, 1'b0, 1'b1, 16'hFFFF); check_state("br_self4", 32'h108, 1'b1, cexp(3), cexp(3));
      do_branch(1'b1, 1'b0, 1'b1, 16'hFFBC); check_state("br_top", 32'hFFFF_FFFC, 1'b1, cexp(3), cexp(3));
      check("top_pc_plus4", bus.pc_plus4, 32'h0);

      // Sequential wrap to zero.
      clear_in(); tick();                 check_state("wrap", 32'h0, 1'b0, cexp(3), cexp(3));
      check("wrap_pc_plus4", bus.pc_plus4, 32'h4);

      // Jump to 0x80, then jump-to-self halts.
      do_jump(24'h000020);                check_state("jmp80", 32'h80, 1'b1, cexp(3), cexp(3));
      check("pre_halt", {31'b0, bus.halted}, 32'd0);
      do_jump(24'h000020);
      check("halt_entry", {31'b0, bus.halted}, 32'd1);
      check("halt_entry_pc", bus.pc, 32'h80);
      for (int i = 0; i < 5; i++) begin
         bus.instr     = $urandom;
         bus.branch_eq = 1'($urandom_range(0, 1));
         bus.branch_ne = 1'($urandom_range(0, 1));
         bus.jump      = 1'($urandom_range(0, 1));
         bus.zero      = 1'($urandom_range(0, 1));
         bus.stall     = 1'($urandom_range(0, 1));
         tick();
         check_state("halt_hold", 32'h80, 1'b0, cexp(3), cexp(3));
         check("halt_flag", {31'b0, bus.halted}, 32'd1);
      end

      // Asynchronous reset mid-cycle, away from any clock edge.
      clear_in();
      #2 reset = 1'b1;
      #1;
      check_state("async_rst", 32'h40, 1'b0, 0, 0);
      check("async_rst_halted", {31'b0, bus.halted}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();                             check_state("post_rst", 32'h44, 1'b0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
